// File: rtl/layer1_seq_pkg.sv
// Shared state encoding, default sizes and counter-width helper for the layer-1 block sequencer.
package layer1_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W1 = 3'd1,
    ST_LOAD_W2 = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_W1_COUNT   = 4096;
  localparam int DEF_W2_COUNT   = 36864;
  localparam int DEF_PXL_COUNT  = 64 * 512 * 512;

  // Bits needed to hold every value from 0 up to and including max_count.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/layer1_block_sequencer_seq_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value flag.
module seq_counter #(
  parameter int WIDTH = 8,
  parameter int TERM  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  assign term = (count == TERM_V);

  // Count enabled events, holding at the terminal value instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {WIDTH{1'b0}};
    end else if (clr) begin
      count <= {WIDTH{1'b0}};
    end else if (en && !term) begin
      count <= count + ONE_V;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/layer1_block_sequencer.sv
// Sequences one basic-block run: load conv1 then conv2 weights, stream pixels, wait for all results.
module layer1_block_sequencer
  import layer1_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int W1_COUNT   = DEF_W1_COUNT,
  parameter int W2_COUNT   = DEF_W2_COUNT,
  parameter int PXL_COUNT  = DEF_PXL_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  valid_weight_out1,
  output logic [DATA_WIDTH-1:0] weight_out1,
  output logic                  valid_weight_out2,
  output logic [DATA_WIDTH-1:0] weight_out2,
  output logic                  valid_pxl_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  input  logic                  blk_valid_in,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state
);

  localparam int W_TOTAL = W1_COUNT + W2_COUNT;
  localparam int WCW     = cnt_width(W_TOTAL);
  localparam int PCW     = cnt_width(PXL_COUNT);

  // A single weight counter spans both loads; the conv1/conv2 boundary is an intermediate value.
  localparam logic [WCW-1:0] W1_LAST  = WCW'(W1_COUNT - 1);
  localparam logic [WCW-1:0] W_LAST   = WCW'(W_TOTAL - 1);
  localparam logic [PCW-1:0] PXL_LAST = PCW'(PXL_COUNT - 1);
  localparam logic [PCW-1:0] PXL_TERM = PCW'(PXL_COUNT);

  seq_state_e     state_r;
  logic [WCW-1:0] w_cnt;
  logic [PCW-1:0] in_cnt;
  logic [PCW-1:0] out_cnt;
  logic           w_full;
  logic           in_full;
  logic           out_full;
  logic           cnt_clr;
  logic           w_fire;
  logic           src_fire;
  logic           blk_count;

  assign cnt_clr   = (state_r == ST_IDLE) && start;
  assign w_ready   = ((state_r == ST_LOAD_W1) || (state_r == ST_LOAD_W2)) && !w_full;
  assign src_ready = (state_r == ST_STREAM) && !in_full;
  assign w_fire    = w_valid && w_ready;
  assign src_fire  = src_valid && src_ready;
  assign blk_count = blk_valid_in && ((state_r == ST_STREAM) || (state_r == ST_DRAIN)) && !out_full;

  assign busy  = (state_r != ST_IDLE);
  assign done  = (state_r == ST_DONE);
  assign state = state_r;

  seq_counter #(.WIDTH(WCW), .TERM(W_TOTAL)) w_cnt_i (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(w_fire), .count(w_cnt), .term(w_full)
  );

  seq_counter #(.WIDTH(PCW), .TERM(PXL_COUNT)) in_cnt_i (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(src_fire), .count(in_cnt), .term(in_full)
  );

  seq_counter #(.WIDTH(PCW), .TERM(PXL_COUNT)) out_cnt_i (
    .clk(clk), .reset(reset), .clr(cnt_clr), .en(blk_count), .count(out_cnt), .term(out_full)
  );

  // Sequencer state plus registered weight/pixel forwarding with one-cycle latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r           <= ST_IDLE;
      valid_weight_out1 <= 1'b0;
      valid_weight_out2 <= 1'b0;
      valid_pxl_out     <= 1'b0;
      weight_out1       <= {DATA_WIDTH{1'b0}};
      weight_out2       <= {DATA_WIDTH{1'b0}};
      pxl_out           <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_weight_out1 <= 1'b0;
      valid_weight_out2 <= 1'b0;
      valid_pxl_out     <= src_fire;
      if (src_fire) begin
        pxl_out <= src_data;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_LOAD_W1;
          end
        end
        ST_LOAD_W1: begin
          if (w_fire) begin
            weight_out1       <= w_data;
            valid_weight_out1 <= 1'b1;
            if (w_cnt == W1_LAST) begin
              state_r <= ST_LOAD_W2;
            end
          end
        end
        ST_LOAD_W2: begin
          if (w_fire) begin
            weight_out2       <= w_data;
            valid_weight_out2 <= 1'b1;
            if (w_cnt == W_LAST) begin
              state_r <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (src_fire && (in_cnt == PXL_LAST)) begin
            state_r <= ST_DRAIN;
          end
        end
        // Results may all have arrived during STREAM; DRAIN still lasts at least one cycle.
        ST_DRAIN: begin
          if (out_cnt == PXL_TERM) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer1_block_sequencer.sv
// Scoreboard bench: stimulus pushes expected words per port, a negedge monitor pops and compares.
module tb_layer1_block_sequencer;

  localparam int DW  = 32;
  localparam int W1  = 4;
  localparam int W2  = 9;
  localparam int NPX = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_ready;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          valid_weight_out1;
  logic [DW-1:0] weight_out1;
  logic          valid_weight_out2;
  logic [DW-1:0] weight_out2;
  logic          valid_pxl_out;
  logic [DW-1:0] pxl_out;
  logic          blk_valid_in = 1'b0;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail = 0;
  int v1_seen = 0;
  int v2_seen = 0;
  int done_seen = 0;
  logic [DW-1:0] exp_w1[$];
  logic [DW-1:0] exp_w2[$];
  logic [DW-1:0] exp_px[$];

  layer1_block_sequencer #(.DATA_WIDTH(DW), .W1_COUNT(W1), .W2_COUNT(W2), .PXL_COUNT(NPX)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .valid_weight_out1(valid_weight_out1), .weight_out1(weight_out1),
    .valid_weight_out2(valid_weight_out2), .weight_out2(weight_out2),
    .valid_pxl_out(valid_pxl_out), .pxl_out(pxl_out),
    .blk_valid_in(blk_valid_in), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // Monitor: every presented output word must be the next one the model expects on that port
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (reset) begin
      if (valid_weight_out1) begin
        v1_seen++;
        if (exp_w1.size() == 0) check("w1_unexpected", weight_out1, 32'hdead0001);
        else begin e = exp_w1.pop_front(); check("w1_data", weight_out1, e); end
      end
      if (valid_weight_out2) begin
        v2_seen++;
        if (exp_w2.size() == 0) check("w2_unexpected", weight_out2, 32'hdead0002);
        else begin e = exp_w2.pop_front(); check("w2_data", weight_out2, e); end
      end
      if (valid_pxl_out) begin
        if (exp_px.size() == 0) check("px_unexpected", pxl_out, 32'hdead0003);
        else begin e = exp_px.pop_front(); check("px_data", pxl_out, e); end
      end
      if (done) done_seen++;
      check1("busy_vs_state", busy, state != 3'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_checks();
    check("rst_state", 32'(state), 32'd0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_w_ready", w_ready, 1'b0);
    check1("rst_src_ready", src_ready, 1'b0);
    check1("rst_v1", valid_weight_out1, 1'b0);
    check1("rst_v2", valid_weight_out2, 1'b0);
    check1("rst_vpx", valid_pxl_out, 1'b0);
    check("rst_w1", weight_out1, 32'd0);
    check("rst_w2", weight_out2, 32'd0);
    check("rst_px", pxl_out, 32'd0);
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_state", 32'(state), 32'd1);
  endtask

  // Send n weights; the k-th accepted word (from 0) belongs to conv1 while k < W1
  task automatic load_weights(input int n, input bit toggle, input bit seq, input bit noise);
    int k = 0;
    int c = 0;
    int b1 = v1_seen;
    int b2 = v2_seen;
    bit vld;
    bit prev_vld = 1'b0;
    bit prev_p1 = 1'b0;
    while (k < n) begin
      @(negedge clk);
      check1("w_ready_load", w_ready, 1'b1);
      check1("v1_latency", valid_weight_out1, prev_vld && prev_p1);
      check1("v2_latency", valid_weight_out2, prev_vld && !prev_p1);
      vld = toggle ? (c % 2 == 0) : 1'b1;
      c++;
      w_valid = vld;
      w_data = seq ? DW'(k + 1) : $urandom();
      blk_valid_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_vld = vld;
      prev_p1 = (k < W1);
      if (vld) begin
        if (k < W1) exp_w1.push_back(w_data);
        else exp_w2.push_back(w_data);
        k++;
      end
    end
    @(negedge clk);
    w_valid = 1'b0;
    blk_valid_in = 1'b0;
    check1("v1_latency_last", valid_weight_out1, prev_p1);
    check1("v2_latency_last", valid_weight_out2, !prev_p1);
    if (n == W1 + W2) begin
      check("state_after_load", 32'(state), 32'd3);
      check1("w_ready_stream", w_ready, 1'b0);
      @(negedge clk);
      check("w1_strobes", 32'(v1_seen - b1), 32'(W1));
      check("w2_strobes", 32'(v2_seen - b2), 32'(W2));
    end
  endtask

  // Pixels back-to-back, each result returned 20 cycles after its pixel
  task automatic stream_lag(input bit start_in_stream);
    for (int c = 0; c < NPX + 20; c++) begin
      @(negedge clk);
      start = start_in_stream && (c == 5);
      if (c == 6) check("stream_hold_state", 32'(state), 32'd3);
      src_valid = (c < NPX);
      src_data = $urandom();
      blk_valid_in = (c >= 20);
      if (c < NPX) begin
        check1("src_ready_stream", src_ready, 1'b1);
        exp_px.push_back(src_data);
      end
      if (c == NPX) begin
        check1("src_ready_drop", src_ready, 1'b0);
        check("drain_state", 32'(state), 32'd4);
      end
    end
  endtask

  // All results counted before the final pixel is accepted
  task automatic stream_early();
    int k = 0;
    int c = 0;
    while (k < NPX - 1) begin
      @(negedge clk);
      check1("src_ready_early", src_ready, 1'b1);
      src_valid = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      src_data = $urandom();
      c++;
      if (src_valid) begin exp_px.push_back(src_data); k++; end
    end
    for (int i = 0; i < NPX; i++) begin
      @(negedge clk);
      src_valid = 1'b0;
      blk_valid_in = 1'b1;
      check("early_stream_state", 32'(state), 32'd3);
    end
    @(negedge clk);
    blk_valid_in = 1'b0;
    check("early_still_stream", 32'(state), 32'd3);
    check1("src_ready_last", src_ready, 1'b1);
    src_valid = 1'b1;
    src_data = $urandom();
    exp_px.push_back(src_data);
  endtask

  task automatic end_seq(input bit start_in_done);
    @(negedge clk);
    src_valid = 1'b0;
    blk_valid_in = 1'b0;
    check("end_drain", 32'(state), 32'd4);
    check1("end_drain_done", done, 1'b0);
    @(negedge clk);
    check("end_done_state", 32'(state), 32'd5);
    check1("end_done_pulse", done, 1'b1);
    check1("end_done_busy", busy, 1'b1);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    check("end_idle", 32'(state), 32'd0);
    check1("end_idle_busy", busy, 1'b0);
    check1("end_idle_done", done, 1'b0);
    @(negedge clk);
    check("end_idle_hold", 32'(state), 32'd0);
  endtask

  initial begin
    #1;
    reset_checks();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Sequential weights, blk_valid noise during load, start pulses in STREAM and DONE
    start_run();
    load_weights(W1 + W2, 1'b0, 1'b1, 1'b1);
    stream_lag(1'b1);
    end_seq(1'b1);
    check("done_count_a", 32'(done_seen), 32'd1);

    // Stalling weight stream with random data, results ahead of the last pixel
    start_run();
    load_weights(W1 + W2, 1'b1, 1'b0, 1'b0);
    stream_early();
    end_seq(1'b0);
    check("done_count_b", 32'(done_seen), 32'd2);

    // Abandon a run inside LOAD_W2, then restart from weight 0
    start_run();
    load_weights(W1 + 6, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_reset_state", 32'(state), 32'd2);
    #2 reset = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    reset = 1'b1;
    check("q_empty_w1_rst", 32'(exp_w1.size()), 32'd0);
    check("q_empty_w2_rst", 32'(exp_w2.size()), 32'd0);
    start_run();
    load_weights(W1 + W2, 1'b0, 1'b1, 1'b0);
    stream_lag(1'b0);
    end_seq(1'b0);

    @(negedge clk);
    check("done_count_total", 32'(done_seen), 32'd3);
    check("q_empty_w1", 32'(exp_w1.size()), 32'd0);
    check("q_empty_w2", 32'(exp_w2.size()), 32'd0);
    check("q_empty_px", 32'(exp_px.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer1_block_sequencer.md
LAYER1_BLOCK_SEQUENCER -- requirements
Module: layer1_block_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the weight and pixel words.
REQ-002 Parameter W1_COUNT, default 4096, number of conv1 weight words (64x64x1x1).
REQ-003 Parameter W2_COUNT, default 36864, number of conv2 weight words (64x64x3x3).
REQ-004 Parameter PXL_COUNT, default 64*512*512, number of pixel words per image in and out.
REQ-005 Ports, in order: clk in 1, the single clock; reset in 1, asynchronous, active-low.
REQ-006 start in 1: a one-cycle pulse that launches one block run; ignored unless idle.
REQ-007 w_valid in 1, w_data in DATA_WIDTH, w_ready out 1: weight stream from memory (valid/ready).
REQ-008 src_valid in 1, src_data in DATA_WIDTH, src_ready out 1: pixel source stream (valid/ready).
REQ-009 valid_weight_out1 out 1, weight_out1 out DATA_WIDTH: conv1 weight port.
REQ-010 valid_weight_out2 out 1, weight_out2 out DATA_WIDTH: conv2 weight port.
REQ-011 valid_pxl_out out 1, pxl_out out DATA_WIDTH: basic block pixel input.
REQ-012 blk_valid_in in 1: the basic block's valid_out, used to count results.
REQ-013 busy out 1, done out 1 (a one-cycle pulse), state out 3 (the current state encoding).

Function
REQ-014 The FSM SHALL have the states IDLE=0, LOAD_W1=1, LOAD_W2=2, STREAM=3, DRAIN=4, DONE=5.
REQ-015 IDLE with start=1 SHALL go to LOAD_W1 on the next edge and clear all counters.
REQ-016 w_ready SHALL be 1 only in LOAD_W1 or LOAD_W2; a word transfers when w_valid and w_ready are both 1.
REQ-017 In LOAD_W1, each transfer SHALL be registered onto weight_out1 with valid_weight_out1=1 the next cycle (latency 1).
REQ-018 In LOAD_W2, each transfer SHALL be registered the same way onto weight_out2/valid_weight_out2.
REQ-019 The W1_COUNT-th transfer SHALL move the FSM to LOAD_W2 on the same edge; the next word goes to conv2, with no bubble.
REQ-020 The W2_COUNT-th LOAD_W2 transfer SHALL move the FSM to STREAM; valid_weight_out1/2 SHALL be 0 outside their own registered transfers.
REQ-021 src_ready SHALL be 1 only in STREAM while in_cnt<PXL_COUNT.
REQ-022 Each src transfer SHALL appear one cycle later on pxl_out with valid_pxl_out=1, otherwise valid_pxl_out=0; there is no backpressure downstream.
REQ-023 The PXL_COUNT-th src transfer SHALL move the FSM to DRAIN.
REQ-024 out_cnt SHALL increment on every blk_valid_in in STREAM and DRAIN; blk_valid_in in any other state SHALL be ignored.
REQ-025 DRAIN SHALL go to DONE when out_cnt reaches PXL_COUNT, including the case where the final count arrives while still in STREAM.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start while not in IDLE SHALL be ignored, with no state or counter change.
REQ-029 Counters SHALL be unsigned, sized $clog2(max count + 1), compared with ==, and never wrap.
REQ-030 A w_valid stall (w_valid=0) SHALL hold the state and counters indefinitely.

Reset
REQ-031 reset=0 SHALL, asynchronously and from any state, force state=IDLE, all counters=0, and outputs w_ready, src_ready, valid_weight_out1, valid_weight_out2, valid_pxl_out, busy and done=0.
REQ-032 Under reset=0, the data outputs weight_out1, weight_out2 and pxl_out SHALL be 0.
REQ-033 Reset mid-run SHALL abandon the run; the next start after release SHALL reload both weight sets from word 0.

Structure
REQ-034 The state encoding and default counts SHALL live in a shared package, layer1_seq_pkg.
REQ-035 A single sub-module, seq_counter (parameterized width and terminal value, with clear, enable and a terminal flag), SHALL be instantiated three times: w_cnt, in_cnt, out_cnt.

Verification (W1_COUNT=4, W2_COUNT=9, PXL_COUNT=16)
REQ-036 Reset, then start, then 13 back-to-back weight words 1..13: words 1-4 appear on port 1 and words 5-13 on port 2, each with one-cycle latency, and state ends at 3.
REQ-037 Weight stream with w_valid toggling every other cycle: same routing as REQ-036, no word lost or duplicated, and both valid strobes total exactly 13.
REQ-038 16 source pixels, then 16 blk_valid_in pulses with a 20-cycle lag: src_ready drops after pixel 16, then done pulses once and busy falls in the same cycle as the return to IDLE.
REQ-039 blk_valid_in count reaching 16 before the last src transfer: the FSM passes DRAIN and reaches DONE one cycle after the count and the move to DRAIN are both satisfied.
REQ-040 reset asserted in LOAD_W2 after 6 words, then start: the first new word appears on weight_out1, not weight_out2.
REQ-041 start pulses in STREAM and again in DONE: no effect, and exactly one done pulse per run.
